// File: rtl/fir_serial_ctrl_if.sv
// Sample-in / coefficient-write / MAC / result bundle for the serial FIR sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic's view.
interface fir_serial_ctrl_if #(
    parameter int in_WIDTH      = 8,
    parameter int filter_LENGTH = 8,
    parameter int counter_size  = $clog2(filter_LENGTH),
    parameter int out_WIDTH     = in_WIDTH*2 + counter_size + 1
);
    logic                           in_valid;
    logic                           in_ready;
    logic signed [in_WIDTH-1:0]     in_sample;
    logic                           coef_wr_en;
    logic        [counter_size-1:0] coef_wr_addr;
    logic signed [in_WIDTH-1:0]     coef_wr_data;
    logic signed [in_WIDTH-1:0]     mac_coef;
    logic signed [in_WIDTH-1:0]     mac_in;
    logic signed [out_WIDTH-1:0]    mac_last_add;
    logic signed [out_WIDTH-1:0]    mac_result;
    logic                           out_valid;
    logic signed [out_WIDTH-1:0]    out_data;

    modport slave (
        input  in_valid, in_sample, coef_wr_en, coef_wr_addr, coef_wr_data, mac_result,
        output in_ready, mac_coef, mac_in, mac_last_add, out_valid, out_data
    );

    modport master (
        output in_valid, in_sample, coef_wr_en, coef_wr_addr, coef_wr_data, mac_result,
        input  in_ready, mac_coef, mac_in, mac_last_add, out_valid, out_data
    );
endinterface

// File: rtl/fir_serial_ctrl.sv
// Serial FIR sequencer: holds delay line and coefficients, walks one tap per clock
// through the external MAC stage and registers the final sum as the filter output.
module fir_serial_ctrl #(
    parameter int in_WIDTH      = 8,
    parameter int filter_LENGTH = 8,
    parameter int counter_size  = $clog2(filter_LENGTH),
    parameter int out_WIDTH     = in_WIDTH*2 + counter_size + 1
) (
    input  logic             clk,
    input  logic             rst,
    fir_serial_ctrl_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_next;

    logic signed [in_WIDTH-1:0]  x [filter_LENGTH];
    logic signed [in_WIDTH-1:0]  c [filter_LENGTH];
    logic signed [out_WIDTH-1:0] acc;
    logic [counter_size-1:0]     cnt;
    logic                        out_valid_q;
    logic signed [out_WIDTH-1:0] out_data_q;

    logic accept;
    logic last_tap;
    logic coef_wr_ok;

    assign last_tap   = (cnt == counter_size'(filter_LENGTH - 1));
    assign coef_wr_ok = bus.coef_wr_en && (32'(bus.coef_wr_addr) < filter_LENGTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        accept           = 1'b0;
        bus.in_ready     = 1'b0;
        bus.mac_coef     = '0;
        bus.mac_in       = '0;
        bus.mac_last_add = '0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                bus.mac_coef     = c[cnt];
                bus.mac_in       = x[cnt];
                bus.mac_last_add = acc;
                if (last_tap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < filter_LENGTH; k++) begin
                x[k] <= '0;
                c[k] <= '0;
            end
            acc         <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            // A write coinciding with an accept lands before the first tap is read.
            if (state == IDLE && coef_wr_ok) begin
                c[bus.coef_wr_addr] <= bus.coef_wr_data;
            end
            if (accept) begin
                for (int unsigned k = filter_LENGTH - 1; k > 0; k--) begin
                    x[k] <= x[k-1];
                end
                x[0] <= bus.in_sample;
                acc  <= '0;
                cnt  <= '0;
            end else if (state == RUN) begin
                if (last_tap) begin
                    out_data_q  <= bus.mac_result;
                    out_valid_q <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                end else begin
                    acc <= bus.mac_result;
                    cnt <= cnt + counter_size'(1);
                end
            end
        end
    end

    always_comb begin
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
    end
endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Scoreboard bench for fir_serial_ctrl: a behavioural dot-product model predicts each
// output value and its cycle; a negedge monitor pops and compares every out_valid.
module tb_fir_serial_ctrl;
    localparam int W  = 8;
    localparam int L  = 8;
    localparam int CS = $clog2(L);
    localparam int OW = W*2 + CS + 1;

    typedef struct {
        logic signed [OW-1:0] val;
        int                   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    fir_serial_ctrl_if #(.in_WIDTH(W), .filter_LENGTH(L)) bus ();

    fir_serial_ctrl #(.in_WIDTH(W), .filter_LENGTH(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Downstream MAC stage: last_add + coef*in, all signed at output width.
    logic signed [OW-1:0] ce, xe;
    assign ce = bus.mac_coef;
    assign xe = bus.mac_in;
    assign bus.mac_result = bus.mac_last_add + ce * xe;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int   ntests = 0;
    int   nfails = 0;
    exp_t sbq[$];
    exp_t mon_item;

    int xm[L];
    int cm[L];
    int last_acc = -1000;

    function automatic void check(string name, longint act, longint exp);
        ntests++;
        if (act != exp) begin
            nfails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(string name);
        ntests++;
        nfails++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endfunction

    function automatic int rnd8();
        int r;
        r = int'($urandom_range(0, 255));
        return r - 128;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < L; k++) begin
            xm[k] = 0;
            cm[k] = 0;
        end
        last_acc = -1000;
        sbq.delete();
    endfunction

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                ntests++;
                nfails++;
                $display("FAIL unexpected_out: got out_valid=1 data=%0d, expected no output (cycle %0d)",
                         bus.out_data, cyc);
            end else begin
                mon_item = sbq.pop_front();
                check("out_data", bus.out_data, mon_item.val);
                check("out_cycle", cyc, mon_item.cyc);
                check("ready_with_valid", bus.in_ready, 1);
            end
        end
    end

    // One clock: drive inputs at a negedge, update the model for the coming edge, return at next negedge.
    task automatic step(input bit v, input int s, input bit we, input int wa, input int wd, output bit acc);
        int e;
        int sum;
        exp_t item;
        bus.in_valid     = v;
        bus.in_sample    = W'(s);
        bus.coef_wr_en   = we;
        bus.coef_wr_addr = CS'(wa);
        bus.coef_wr_data = W'(wd);
        e   = cyc + 1;
        acc = v && (bus.in_ready === 1'b1) && !rst;
        if (we && !rst && wa < L && !(e > last_acc && e <= last_acc + L))
            cm[wa] = wd;
        if (acc) begin
            for (int k = L - 1; k > 0; k--) xm[k] = xm[k-1];
            xm[0] = s;
            sum = 0;
            for (int k = 0; k < L; k++) sum += cm[k] * xm[k];
            item.val = OW'(sum);
            item.cyc = e + L;
            sbq.push_back(item);
            last_acc = e;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(0, 0, 0, 0, 0, a);
    endtask

    task automatic write_coef(input int wa, input int wd);
        bit a;
        step(0, 0, 1, wa, wd, a);
    endtask

    task automatic send(input int s);
        bit a;
        int n;
        a = 0;
        n = 0;
        while (!a && n < 40) begin
            step(1, s, 0, 0, 0, a);
            n++;
        end
        if (!a) fail_now("send_accept");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            idle(1);
            n++;
        end
        if (sbq.size() != 0) fail_now("drain");
        idle(1);
    endtask

    task automatic do_reset();
        bit a;
        rst = 1'b1;
        step(0, 0, 0, 0, 0, a);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int nxt, prev, n;
        bus.in_valid     = 1'b0;
        bus.in_sample    = '0;
        bus.coef_wr_en   = 1'b0;
        bus.coef_wr_addr = '0;
        bus.coef_wr_data = '0;
        model_clear();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_mac_coef", bus.mac_coef, 0);
        check("rst_mac_in", bus.mac_in, 0);
        check("rst_mac_last_add", bus.mac_last_add, 0);

        send(5);
        drain();
        check("zero_coef_out", bus.out_data, 0);

        // Impulse response
        for (int k = 0; k < L; k++) write_coef(k, k + 1);
        send(1);
        drain();
        for (int k = 1; k < L; k++) begin
            send(0);
            drain();
        end
        check("impulse_tail", bus.out_data, 8);
        send(0);
        drain();
        check("impulse_flushed", bus.out_data, 0);
        check("idle_mac_last_add", bus.mac_last_add, 0);

        // Full scale, no wrap
        for (int k = 0; k < L; k++) write_coef(k, -128);
        for (int k = 0; k < L; k++) begin
            send(-128);
            drain();
        end
        check("fullscale_nn", bus.out_data, 131072);
        for (int k = 0; k < L; k++) write_coef(k, 127);
        for (int k = 0; k < L; k++) begin
            send(-128);
            drain();
        end
        check("fullscale_pn", bus.out_data, -130048);

        // Streaming with in_valid held high
        for (int k = 0; k < L; k++) write_coef(k, rnd8());
        nxt = 1;
        prev = -1;
        n = 0;
        while (nxt <= 6 && n < 100) begin
            step(1, nxt, 0, 0, 0, a);
            n++;
            if (a) begin
                if (prev >= 0) check("stream_gap", last_acc - prev, L + 1);
                prev = last_acc;
                nxt++;
            end
        end
        if (nxt <= 6) fail_now("stream_accepts");
        drain();

        // Coefficient write during RUN is dropped; in IDLE it applies
        send(rnd8());
        idle(2);
        write_coef(0, 50);
        drain();
        send(rnd8() | 1);
        drain();
        write_coef(0, 50);
        send(rnd8() | 1);
        drain();
        step(1, 77, 1, 1, -3, a);
        if (!a) fail_now("simul_accept");
        drain();

        // Randomised traffic with writes at arbitrary times
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, rnd8(), $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, L - 1)), rnd8(), a);
        end
        drain();

        // Reset mid-RUN at cnt=4
        for (int k = 0; k < L; k++) write_coef(k, rnd8());
        send(rnd8());
        idle(4);
        do_reset();
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data", bus.out_data, 0);
        idle(12);
        send(rnd8());
        drain();
        check("post_rst_zero", bus.out_data, 0);
        for (int k = 0; k < L; k++) write_coef(k, 1);
        send(3);
        drain();

        idle(3);
        if (sbq.size() != 0) fail_now("leftover_expect");
        $display("[TB] %0d tests run, %0d failed", ntests, nfails);
        $finish;
    end
endmodule
